// File: rtl/ni_inject.sv
// Network-interface injection unit: queues whole messages from a core and serialises them
// into credit-gated flits for the attached router's local input port.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module ni_inject #(
    parameter int FLIT_W      = `FLIT_DATA_WIDTH,
    parameter int NUM_ROUTERS = 16,
    parameter int ROUTER_ID   = 0,
    parameter int NUM_VC      = 4,
    parameter int NUM_FLITS   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int RID_W       = $clog2(NUM_ROUTERS),
    parameter int SEQ_W       = $clog2(NUM_FLITS),
    parameter int CHUNK_W     = FLIT_W - 2*RID_W - SEQ_W,
    parameter int MSG_W       = NUM_FLITS*CHUNK_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           msg_valid,
    output logic                           msg_ready,
    input  logic [RID_W-1:0]               msg_dest,
    input  logic [MSG_W-1:0]               msg_data,
    input  logic                           credit_in,
    output logic [FLIT_W-1:0]              flit_data,
    output logic                           flit_valid,
    output logic [$clog2(NUM_VC+1)-1:0]    credits_avail,
    output logic                           busy,
    output logic                           credit_err
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CRED_W  = $clog2(NUM_VC+1);
    localparam int ENTRY_W = RID_W + MSG_W;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state, state_n;
    logic [SEQ_W-1:0]     seq, seq_n;
    logic                 load, pop, issue, push, full, empty;

    logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    logic [RID_W-1:0]     head_dest;
    logic [MSG_W-1:0]     head_data;

    logic [RID_W-1:0]     msg_dest_r;
    logic [MSG_W-1:0]     msg_data_r;
    logic [CHUNK_W-1:0]   chunk;
    logic [FLIT_W-1:0]    flit_next;
    logic [CRED_W-1:0]    credits;

    assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign msg_ready = !full;
    assign push      = msg_valid && !full;
    assign busy      = !empty || (state == SEND);
    assign credits_avail = credits;
    assign {head_dest, head_data} = fifo_mem[rd_ptr];

    // Message queue: pointers wrap naturally since FIFO_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {msg_dest, msg_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            seq   <= '0;
        end else begin
            state <= state_n;
            seq   <= seq_n;
        end
    end

    // Last flit with a queued message reloads in the same edge so back-to-back messages have no bubble
    always_comb begin
        state_n = state;
        seq_n   = seq;
        load    = 1'b0;
        pop     = 1'b0;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    pop     = 1'b1;
                    seq_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (credits != '0) begin
                    issue = 1'b1;
                    seq_n = seq + SEQ_W'(1);
                    if (seq == SEQ_W'(NUM_FLITS-1)) begin
                        seq_n = '0;
                        if (!empty) begin
                            load = 1'b1;
                            pop  = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load) begin
            msg_dest_r <= head_dest;
            msg_data_r <= head_data;
        end
    end

    assign chunk     = msg_data_r[seq*CHUNK_W +: CHUNK_W];
    assign flit_next = {msg_dest_r, RID_W'(ROUTER_ID), seq, chunk};

    always_ff @(posedge clk) begin
        if (reset) begin
            flit_valid <= 1'b0;
            flit_data  <= '0;
        end else begin
            flit_valid <= issue;
            if (issue) flit_data <= flit_next;
        end
    end

    // A returned credit and an issued flit in the same cycle cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            credits    <= CRED_W'(NUM_VC);
            credit_err <= 1'b0;
        end else begin
            if (credit_in && !issue) begin
                if (credits == CRED_W'(NUM_VC)) credit_err <= 1'b1;
                else                             credits    <= credits + CRED_W'(1);
            end else if (!credit_in && issue) begin
                credits <= credits - CRED_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ni_inject.sv
// Scoreboard bench for ni_inject: stimulus queues expected flits, a negedge monitor checks them.
module tb_ni_inject;

    localparam int FLIT_W  = 32;
    localparam int RID_W   = 4;
    localparam int CHUNK_W = 22;
    localparam int MSG_W   = 88;

    logic              clk;
    logic              reset;
    logic              msg_valid;
    logic              msg_ready;
    logic [RID_W-1:0]  msg_dest;
    logic [MSG_W-1:0]  msg_data;
    logic              credit_in;
    logic [FLIT_W-1:0] flit_data;
    logic              flit_valid;
    logic [2:0]        credits_avail;
    logic              busy;
    logic              credit_err;

    ni_inject #(
        .FLIT_W(32), .NUM_ROUTERS(16), .ROUTER_ID(0),
        .NUM_VC(4), .NUM_FLITS(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_dest(msg_dest), .msg_data(msg_data),
        .credit_in(credit_in),
        .flit_data(flit_data), .flit_valid(flit_valid),
        .credits_avail(credits_avail), .busy(busy), .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [FLIT_W-1:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MSG_W-1:0] mk_msg(input logic [21:0] a, input logic [21:0] b,
                                                input logic [21:0] c, input logic [21:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [FLIT_W-1:0] mk_flit(input logic [3:0] dest, input int k,
                                                  input logic [MSG_W-1:0] data);
        logic [21:0] c;
        logic [1:0]  s;
        c = data[k*CHUNK_W +: CHUNK_W];
        s = 2'(k);
        return {dest, 4'h0, s, c};
    endfunction

    task automatic expect_msg(input logic [3:0] dest, input logic [MSG_W-1:0] data);
        for (int k = 0; k < 4; k++) sb.push_back(mk_flit(dest, k, data));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_msg(input logic [3:0] dest, input logic [MSG_W-1:0] data,
                            input int limit, output bit ok);
        ok        = 1'b0;
        msg_valid = 1'b1;
        msg_dest  = dest;
        msg_data  = data;
        for (int i = 0; i < limit; i++) begin
            if (msg_ready) begin
                ok = 1'b1;
                expect_msg(dest, data);
                tick();
                break;
            end
            tick();
        end
        msg_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        msg_valid = 1'b0;
        credit_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (flit_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit: got %0h expected none", flit_data);
            end else begin
                logic [FLIT_W-1:0] e;
                e = sb.pop_front();
                if (flit_data !== e) begin
                    errors++;
                    $display("FAIL flit: got %0h expected %0h", flit_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        int bubbles;
        logic [MSG_W-1:0] d;

        msg_dest = '0;
        msg_data = '0;
        do_reset();
        chk("rst_valid",   flit_valid, 0);
        chk("rst_data",    flit_data, 0);
        chk("rst_credits", credits_avail, 4);
        chk("rst_busy",    busy, 0);
        chk("rst_err",     credit_err, 0);
        chk("rst_ready",   msg_ready, 1);

        // single message, latency and format
        msg_valid = 1'b1;
        msg_dest  = 4'd5;
        msg_data  = mk_msg(22'hA, 22'hB, 22'hC, 22'hD);
        sb.push_back(32'h5000000A);
        sb.push_back(32'h5040000B);
        sb.push_back(32'h5080000C);
        sb.push_back(32'h50C0000D);
        tick();
        msg_valid = 1'b0;
        chk("t1_lat_e0", flit_valid, 0);
        tick();
        chk("t1_lat_e1", flit_valid, 0);
        tick();
        chk("t1_lat_e2", flit_valid, 1);
        chk("t1_cred_e2", credits_avail, 3);
        repeat (6) tick();
        chk("t1_credits", credits_avail, 0);
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_busy", busy, 0);

        // zero credits: stall, then one credit yields exactly one flit
        d = mk_msg(22'h111, 22'h222, 22'h333, 22'h3FFFFF);
        push_msg(4'd3, d, 4, ok);
        chk("t2_accept", ok, 1);
        repeat (6) tick();
        chk("t2_stall_sb", sb.size(), 4);
        chk("t2_stall_valid", flit_valid, 0);
        chk("t2_busy", busy, 1);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        tick();
        chk("t2_one_flit", flit_valid, 1);
        repeat (4) tick();
        chk("t2_one_sb", sb.size(), 3);
        for (int i = 0; i < 3; i++) begin
            credit_in = 1'b1;
            tick();
            credit_in = 1'b0;
            repeat (3) tick();
        end
        chk("t2_drain_sb", sb.size(), 0);
        chk("t2_drain_busy", busy, 0);
        chk("t2_drain_cred", credits_avail, 0);
        for (int i = 0; i < 4; i++) begin
            credit_in = 1'b1;
            tick();
            credit_in = 1'b0;
            tick();
        end
        chk("t2_refill", credits_avail, 4);
        chk("t2_err", credit_err, 0);

        // three back-to-back messages with credits held full
        msg_valid = 1'b1;
        msg_dest = 4'd1; msg_data = mk_msg(22'h10, 22'h11, 22'h12, 22'h13);
        expect_msg(msg_dest, msg_data);
        tick();
        msg_dest = 4'd2; msg_data = mk_msg(22'h20, 22'h21, 22'h22, 22'h23);
        expect_msg(msg_dest, msg_data);
        tick();
        msg_dest = 4'd0; msg_data = mk_msg(22'h30, 22'h31, 22'h32, 22'h33);
        expect_msg(msg_dest, msg_data);
        credit_in = 1'b1;
        tick();
        msg_valid = 1'b0;
        bubbles = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!flit_valid) bubbles++;
        end
        credit_in = 1'b0;
        chk("t3_no_bubble", bubbles, 0);
        tick();
        chk("t3_end_valid", flit_valid, 0);
        chk("t3_credits", credits_avail, 4);
        chk("t3_err", credit_err, 0);
        chk("t3_sb_empty", sb.size(), 0);

        // credit return at full count
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("t5_cred_cap", credits_avail, 4);
        chk("t5_err_set", credit_err, 1);

        // simultaneous credit and issue at credits=2
        d = mk_msg(22'h2AAAAA, 22'h155555, 22'h0, 22'h1);
        push_msg(4'd15, d, 4, ok);
        chk("t5_accept", ok, 1);
        tick();
        tick();
        tick();
        chk("t5_pre", credits_avail, 2);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("t5_same_cycle", credits_avail, 2);
        repeat (3) tick();
        chk("t5_sb_empty", sb.size(), 0);
        chk("t5_credits", credits_avail, 1);
        chk("t5_err_sticky", credit_err, 1);

        // fill the queue behind a stalled message
        d = mk_msg(22'h70, 22'h71, 22'h72, 22'h73);
        push_msg(4'd7, d, 4, ok);
        chk("t4_accept_x", ok, 1);
        repeat (6) tick();
        chk("t4_stall_sb", sb.size(), 3);
        for (int i = 0; i < 4; i++) begin
            d = mk_msg(22'(i), 22'(i + 16), 22'(i + 32), 22'(i + 48));
            push_msg(4'(i + 8), d, 2, ok);
            chk("t4_accept_q", ok, 1);
        end
        chk("t4_full", msg_ready, 0);
        msg_valid = 1'b1;
        msg_dest  = 4'd12;
        msg_data  = mk_msg(22'hC0, 22'hC1, 22'hC2, 22'hC3);
        repeat (4) tick();
        chk("t4_held_ready", msg_ready, 0);
        chk("t4_held_sb", sb.size(), 19);
        credit_in = 1'b1;
        push_msg(4'd12, mk_msg(22'hC0, 22'hC1, 22'hC2, 22'hC3), 20, ok);
        chk("t4_accept_after_pop", ok, 1);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !busy) break;
            tick();
        end
        credit_in = 1'b0;
        chk("t4_drain_sb", sb.size(), 0);
        chk("t4_drain_busy", busy, 0);

        // reset mid-message
        do_reset();
        chk("t6_rst_credits", credits_avail, 4);
        chk("t6_rst_err", credit_err, 0);
        d = mk_msg(22'h90, 22'h91, 22'h92, 22'h93);
        push_msg(4'd9, d, 4, ok);
        chk("t6_accept", ok, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (flit_valid && flit_data[23:22] == 2'd1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t6_seq1_seen", seen, 1);
        reset = 1'b1;
        tick();
        chk("t6_valid_drop", flit_valid, 0);
        sb.delete();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("t6_credits", credits_avail, 4);
        chk("t6_busy", busy, 0);
        chk("t6_valid", flit_valid, 0);
        chk("t6_data", flit_data, 0);
        chk("t6_ready", msg_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
